// File: rtl/vram_write_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : vram_write_ctrl_if
//  Description : Bundle of the clear-engine controls, the two pixel-draw
//                valid/ready requesters and the frame-buffer write side of
//                vram_write_ctrl. "master" is the drawing side that issues
//                requests; "slave" is the write controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vram_write_ctrl_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 12
);
    // Clear engine
    logic                  clear_start;
    logic [DATA_WIDTH-1:0] clear_color;
    logic                  clear_busy;

    // Requester 0
    logic                  p0_valid;
    logic                  p0_ready;
    logic [9:0]            p0_x;
    logic [8:0]            p0_y;
    logic [DATA_WIDTH-1:0] p0_color;

    // Requester 1
    logic                  p1_valid;
    logic                  p1_ready;
    logic [9:0]            p1_x;
    logic [8:0]            p1_y;
    logic [DATA_WIDTH-1:0] p1_color;

    // Frame-buffer write port
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  oob_err;

    modport master (
        output clear_start, clear_color,
        output p0_valid, p0_x, p0_y, p0_color,
        output p1_valid, p1_x, p1_y, p1_color,
        input  clear_busy, p0_ready, p1_ready,
        input  we, write_addr, write_data, oob_err
    );

    modport slave (
        input  clear_start, clear_color,
        input  p0_valid, p0_x, p0_y, p0_color,
        input  p1_valid, p1_x, p1_y, p1_color,
        output clear_busy, p0_ready, p1_ready,
        output we, write_addr, write_data, oob_err
    );
endinterface
`default_nettype wire

// File: rtl/vram_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vram_write_ctrl
//  Description : Owner of the frame-buffer write port. Arbitrates two pixel
//                requesters, converts (x, y) to a linear address, drops
//                off-screen pixels (flagging oob_err) and runs a full-screen
//                clear engine that fills every location with one colour.
//                Build option VRAM_WR_RR_ARB_EN: round-robin arbitration
//                between the requesters; undefined gives fixed priority
//                with requester 0 winning on contention.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_write_ctrl #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    vram_write_ctrl_if.slave bus
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    localparam int                    c_TOTAL     = H_RES * V_RES;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_TOTAL - 1);
    // One extra bit so x up to 1023 and y up to 511 compare cleanly
    localparam logic [10:0]           c_H_LIM     = 11'(H_RES);
    localparam logic [9:0]            c_V_LIM     = 10'(V_RES);

    logic [0:0]            r_state;
    logic [0:0]            w_next_state;

    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_clear_color;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_write_addr;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic                  r_oob_err;

    logic                  w_p0_ready;
    logic                  w_p1_ready;
    logic                  w_clear_busy;
    logic                  w_pref_p1;
    logic                  w_xfer;
    logic                  w_sel_p1;

    logic [9:0]            w_sel_x;
    logic [8:0]            w_sel_y;
    logic [DATA_WIDTH-1:0] w_sel_color;
    logic [ADDR_WIDTH-1:0] w_x_ext;
    logic [ADDR_WIDTH-1:0] w_y_ext;
    logic [ADDR_WIDTH-1:0] w_row_base;
    logic [ADDR_WIDTH-1:0] w_pix_addr;
    logic                  w_in_range;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: clear_start opens a clear, the last address closes it
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.clear_start) begin
                    w_next_state = c_CLEAR;
                end
            end
            c_CLEAR: begin
                if (r_cnt == c_LAST_ADDR) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs of the FSM: at most one ready, only in IDLE, never on clear_start
    always_comb begin
        w_p0_ready   = 1'b0;
        w_p1_ready   = 1'b0;
        w_clear_busy = (r_state == c_CLEAR);
        if ((r_state == c_IDLE) && !bus.clear_start) begin
            if (bus.p0_valid && bus.p1_valid) begin
                w_p1_ready = w_pref_p1;
                w_p0_ready = ~w_pref_p1;
            end else begin
                w_p0_ready = bus.p0_valid;
                w_p1_ready = bus.p1_valid;
            end
        end
    end

`ifdef VRAM_WR_RR_ARB_EN
    logic r_rr_ptr;

    // After every accepted transfer, hand the contention preference to the other port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_xfer) begin
            r_rr_ptr <= ~w_sel_p1;
        end
    end

    assign w_pref_p1 = r_rr_ptr;
`else
    assign w_pref_p1 = 1'b0;
`endif

    // A ready is only ever raised alongside its valid, so ready alone names the winner
    assign w_sel_p1    = w_p1_ready;
    assign w_xfer      = (bus.p0_valid && w_p0_ready) || (bus.p1_valid && w_p1_ready);
    assign w_sel_x     = w_sel_p1 ? bus.p1_x     : bus.p0_x;
    assign w_sel_y     = w_sel_p1 ? bus.p1_y     : bus.p0_y;
    assign w_sel_color = w_sel_p1 ? bus.p1_color : bus.p0_color;

    assign w_x_ext = ADDR_WIDTH'(w_sel_x);
    assign w_y_ext = ADDR_WIDTH'(w_sel_y);

    generate
        if (H_RES == 640) begin : g_row_shift_add
            // y*640 = y*512 + y*128
            assign w_row_base = (w_y_ext << 9) + (w_y_ext << 7);
        end else begin : g_row_mult
            assign w_row_base = w_y_ext * ADDR_WIDTH'(H_RES);
        end
    endgenerate

    assign w_pix_addr = w_row_base + w_x_ext;
    assign w_in_range = ({1'b0, w_sel_x} < c_H_LIM) && ({1'b0, w_sel_y} < c_V_LIM);

    // Write port: clear sweep, accepted pixel one cycle later, or idle hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_clear_color <= '0;
            r_we          <= 1'b0;
            r_write_addr  <= '0;
            r_write_data  <= '0;
            r_oob_err     <= 1'b0;
        end else begin
            r_oob_err <= 1'b0;
            if (r_state == c_CLEAR) begin
                // Output already shows address r_cnt; advance or finish
                if (r_cnt == c_LAST_ADDR) begin
                    r_we  <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_cnt        <= r_cnt + ADDR_WIDTH'(1);
                    r_we         <= 1'b1;
                    r_write_addr <= r_cnt + ADDR_WIDTH'(1);
                    r_write_data <= r_clear_color;
                end
            end else if (bus.clear_start) begin
                // First clear write (address 0) appears with clear_busy
                r_clear_color <= bus.clear_color;
                r_cnt         <= '0;
                r_we          <= 1'b1;
                r_write_addr  <= '0;
                r_write_data  <= bus.clear_color;
            end else if (w_xfer) begin
                if (w_in_range) begin
                    r_we         <= 1'b1;
                    r_write_addr <= w_pix_addr;
                    r_write_data <= w_sel_color;
                end else begin
                    r_we      <= 1'b0;
                    r_oob_err <= 1'b1;
                end
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.p0_ready   = w_p0_ready;
    assign bus.p1_ready   = w_p1_ready;
    assign bus.clear_busy = w_clear_busy;
    assign bus.we         = r_we;
    assign bus.write_addr = r_write_addr;
    assign bus.write_data = r_write_data;
    assign bus.oob_err    = r_oob_err;

endmodule
`default_nettype wire

// File: tb/tb_vram_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_write_ctrl
//  Description : Scoreboard bench for vram_write_ctrl. Expected writes and
//                off-screen pulses are queued as stimulus is issued; a
//                monitor pops and compares on every we/oob_err cycle.
//                A 640x24 frame keeps each full clear short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_write_ctrl;

    localparam int H     = 640;
    localparam int V     = 24;
    localparam int AW    = 19;
    localparam int DW    = 12;
    localparam int TOTAL = H * V;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vram_write_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    vram_write_ctrl #(
        .H_RES     (H),
        .V_RES     (V),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic          oob;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

`ifdef VRAM_WR_RR_ARB_EN
    localparam logic [3:0] c_ARB_P1 = 4'b1010;  // bit i: p1 wins step i
`else
    localparam logic [3:0] c_ARB_P1 = 4'b0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic oob, input int a, input logic [DW-1:0] d);
        exp_t e;
        e.oob  = oob;
        e.addr = AW'(a);
        e.data = d;
        q.push_back(e);
    endtask

    // Monitor: every write or off-screen pulse must match the next queued entry
    always @(negedge clk) begin
        exp_t e;
        if (bus.we === 1'b1 || bus.oob_err === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: we=%b oob=%b addr=%0d data=%0h expected none",
                         bus.we, bus.oob_err, bus.write_addr, bus.write_data);
            end else begin
                e = q.pop_front();
                check("sb_oob", 32'(bus.oob_err), 32'(e.oob));
                if (e.oob) begin
                    check("sb_oob_we", 32'(bus.we), 32'd0);
                end else begin
                    check("sb_addr", 32'(bus.write_addr), 32'(e.addr));
                    check("sb_data", 32'(bus.write_data), 32'(e.data));
                end
            end
        end
    end

    task automatic reset_dut();
        reset         = 1'b1;
        bus.p0_valid  = 1'b0;
        bus.p1_valid  = 1'b0;
        bus.clear_start = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Single pixel on one port; expects acceptance in the current (idle) cycle
    task automatic send_px(input int port, input int x, input int y, input logic [DW-1:0] c);
        logic ok;
        ok = (x < H) && (y < V);
        if (port == 0) begin
            bus.p0_x = 10'(x); bus.p0_y = 9'(y); bus.p0_color = c; bus.p0_valid = 1'b1;
        end else begin
            bus.p1_x = 10'(x); bus.p1_y = 9'(y); bus.p1_color = c; bus.p1_valid = 1'b1;
        end
        #1;
        check($sformatf("px_ready_p%0d", port),
              32'(port == 0 ? bus.p0_ready : bus.p1_ready), 32'd1);
        check($sformatf("px_other_ready_p%0d", port),
              32'(port == 0 ? bus.p1_ready : bus.p0_ready), 32'd0);
        push(!ok, ok ? y * H + x : 0, c);
        tick();
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        if (ok) begin
            check("px_lat_we", 32'(bus.we), 32'd1);
            check("px_lat_addr", 32'(bus.write_addr), 32'(y * H + x));
            check("px_lat_data", 32'(bus.write_data), 32'(c));
            last_addr = AW'(y * H + x);
            last_data = c;
        end else begin
            check("oob_we", 32'(bus.we), 32'd0);
            check("oob_err", 32'(bus.oob_err), 32'd1);
            check("oob_hold_addr", 32'(bus.write_addr), 32'(last_addr));
            check("oob_hold_data", 32'(bus.write_data), 32'(last_data));
        end
    endtask

    // Runs until clear_busy drops; counts busy cycles, writes and stray p1 grants
    task automatic wait_clear(output int busy, output int wes, output int rdy, output logic done);
        busy = 0; wes = 0; rdy = 0; done = 1'b0;
        for (int k = 0; k < TOTAL + 100 && !done; k++) begin
            #1;
            if (bus.clear_busy === 1'b1) begin
                busy++;
                if (bus.we === 1'b1) wes++;
                if (bus.p1_ready !== 1'b0 || bus.p0_ready !== 1'b0) rdy++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
    endtask

    initial begin
        int   busy, wes, rdy;
        logic done;

        reset           = 1'b1;
        bus.clear_start = 1'b0;
        bus.clear_color = '0;
        bus.p0_valid = 1'b0; bus.p0_x = '0; bus.p0_y = '0; bus.p0_color = '0;
        bus.p1_valid = 1'b0; bus.p1_x = '0; bus.p1_y = '0; bus.p1_color = '0;
        last_addr = '0;
        last_data = '0;

        // Reset state
        repeat (3) tick();
        check("rst_we",    32'(bus.we),         32'd0);
        check("rst_addr",  32'(bus.write_addr), 32'd0);
        check("rst_data",  32'(bus.write_data), 32'd0);
        check("rst_busy",  32'(bus.clear_busy), 32'd0);
        check("rst_oob",   32'(bus.oob_err),    32'd0);
        check("rst_p0rdy", 32'(bus.p0_ready),   32'd0);
        check("rst_p1rdy", 32'(bus.p1_ready),   32'd0);
        reset = 1'b0;
        tick();

        // Basic pixel: (3,2) -> 2*640+3 = 1283
        send_px(0, 3, 2, 12'hF00);
        tick();

        // Contention for four cycles from a fresh pointer
        reset_dut();
        bus.p0_x = 10'd10; bus.p0_y = 9'd0; bus.p0_color = 12'h111;
        bus.p1_x = 10'd20; bus.p1_y = 9'd1; bus.p1_color = 12'h222;
        bus.p0_valid = 1'b1;
        bus.p1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("arb%0d_p0_ready", i), 32'(bus.p0_ready), 32'(!c_ARB_P1[i]));
            check($sformatf("arb%0d_p1_ready", i), 32'(bus.p1_ready), 32'(c_ARB_P1[i]));
            if (c_ARB_P1[i]) push(1'b0, 660, 12'h222);
            else             push(1'b0, 10, 12'h111);
            tick();
        end
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        tick();

        // Full clear with p1 waiting; p1 (5,5) lands right after
        bus.p1_x = 10'd5; bus.p1_y = 9'd5; bus.p1_color = 12'hABC; bus.p1_valid = 1'b1;
        bus.clear_color = 12'h0A5;
        bus.clear_start = 1'b1;
        #1;
        check("clr_start_p1rdy", 32'(bus.p1_ready), 32'd0);
        check("clr_start_p0rdy", 32'(bus.p0_ready), 32'd0);
        for (int a = 0; a < TOTAL; a++) push(1'b0, a, 12'h0A5);
        push(1'b0, 5 * H + 5, 12'hABC);
        tick();
        bus.clear_start = 1'b0;
        bus.clear_color = '0;
        wait_clear(busy, wes, rdy, done);
        check("clr_done",      32'(done), 32'd1);
        check("clr_busy_cyc",  32'(busy), 32'(TOTAL));
        check("clr_writes",    32'(wes),  32'(TOTAL));
        check("clr_ready_hit", 32'(rdy),  32'd0);
        check("clr_p1_first_idle", 32'(bus.p1_ready), 32'd1);
        tick();
        bus.p1_valid = 1'b0;
        check("clr_p1_we",   32'(bus.we),         32'd1);
        check("clr_p1_addr", 32'(bus.write_addr), 32'(5 * H + 5));
        last_addr = AW'(5 * H + 5);
        last_data = 12'hABC;
        tick();

        // Off-screen pixels and the last on-screen location
        send_px(1, 640, 0, 12'h123);
        send_px(1, 0, 480, 12'h456);
        send_px(1, 0, V, 12'h789);
        send_px(1, H - 1, V - 1, 12'h0F0);
        tick();

        // Reset while address 1000 is on the port
        bus.clear_color = 12'h3C3;
        bus.clear_start = 1'b1;
        for (int a = 0; a <= 1000; a++) push(1'b0, a, 12'h3C3);
        tick();
        bus.clear_start = 1'b0;
        repeat (1000) tick();
        reset = 1'b1;
        tick();
        check("rstclr_we",   32'(bus.we),         32'd0);
        check("rstclr_busy", 32'(bus.clear_busy), 32'd0);
        reset = 1'b0;
        last_addr = '0;
        last_data = '0;
        send_px(0, 1, 1, 12'h0F0);
        tick();

        // clear_start at address 5000 must not restart the sweep
        bus.clear_color = 12'h5A5;
        bus.clear_start = 1'b1;
        for (int a = 0; a < TOTAL; a++) push(1'b0, a, 12'h5A5);
        tick();
        bus.clear_start = 1'b0;
        repeat (5000) tick();
        bus.clear_start = 1'b1;
        bus.clear_color = 12'hFFF;
        tick();
        bus.clear_start = 1'b0;
        bus.clear_color = '0;
        wait_clear(busy, wes, rdy, done);
        check("reclr_done",     32'(done), 32'd1);
        check("reclr_busy_cyc", 32'(busy), 32'(TOTAL - 5001));
        check("reclr_ready",    32'(rdy),  32'd0);
        repeat (4) tick();
        check("reclr_idle_we",  32'(bus.we), 32'd0);
        check("sb_drained",     32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_write_ctrl.md
Name: vram_write_ctrl

Overview:
- Owns the single write port of the 640x480, 12-bit frame buffer.
- Shares that port between two pixel-draw requesters using valid/ready handshakes.
- Runs a full-screen clear engine that fills every location with one colour.
- Converts (x, y) coordinates to linear addresses and drops off-screen pixels.
- Sits between the drawing logic and the frame-buffer RAM write side; the display read side is untouched.

Parameters:
- H_RES, 640, horizontal pixels per line
- V_RES, 480, visible lines
- ADDR_WIDTH, 19, frame-buffer address width
- DATA_WIDTH, 12, pixel colour width (4-bit R, G, B)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- clear_start  in  1  single-cycle request to clear the whole frame
- clear_color  in  DATA_WIDTH  fill colour, sampled with clear_start
- clear_busy  out  1  high while the clear engine owns the write port
- p0_valid  in  1  requester 0 has a pixel
- p0_ready  out  1  requester 0 pixel accepted this cycle when valid is also high
- p0_x  in  10  requester 0 column
- p0_y  in  9  requester 0 row
- p0_color  in  DATA_WIDTH  requester 0 colour
- p1_valid, p1_ready, p1_x, p1_y, p1_color  same as p0, for requester 1
- we  out  1  frame-buffer write enable
- write_addr  out  ADDR_WIDTH  frame-buffer write address
- write_data  out  DATA_WIDTH  frame-buffer write data
- oob_err  out  1  one-cycle pulse: an accepted pixel was off-screen

Behaviour:
- Reset values:
  - we, write_addr, write_data, clear_busy, oob_err = 0
  - p0_ready = p1_ready = 0
  - state = IDLE; clear counter = 0; round-robin pointer = 0 (port 0 preferred)
- Reset mid-clear: aborts the clear. No write occurs in the cycle after reset is sampled.
- States:
  - IDLE: serves pixel requests.
  - CLEAR: clear engine owns the port.
- IDLE -> CLEAR: when clear_start=1.
  - clear_color is latched; counter = 0.
  - clear_busy=1 from the next cycle.
  - clear_start has priority: no pixel is accepted in that cycle (both ready=0).
- CLEAR, every cycle:
  - we=1, write_addr=counter, write_data=latched colour; counter increments.
  - After issuing address H_RES*V_RES-1 (307199): return to IDLE and clear_busy=0 in the following cycle.
  - Total clear = exactly 307200 consecutive write cycles.
  - clear_start is ignored; both ready=0.
- Ready and handshake:
  - pN_ready is combinational from state, valid inputs and the pointer.
  - At most one ready is high per cycle; ready is only high in IDLE, and never when clear_start=1.
  - Transfer occurs when valid && ready in the same cycle.
  - Requesters must hold x/y/color stable while valid and not ready.
- Arbitration (fixed priority, round-robin per optional feature):
  - Only one valid: that port is granted.
  - Both valid: grant goes to the port the pointer selects.
  - Pointer updates only on an accepted transfer, to point at the other port.
- Pixel write latency:
  - Transfer accepted in cycle N -> we=1 in cycle N+1 with write_addr = y*H_RES + x and write_data = color.
  - Back-to-back transfers give one write per cycle.
- Width rules:
  - Address arithmetic is done in ADDR_WIDTH bits.
  - Maximum in-range result is 307199, so no overflow.
  - y*640 may be built as (y<<9)+(y<<7).
- Off-screen pixels (x >= H_RES or y >= V_RES):
  - Accepted normally, so ready behaviour is unchanged.
  - In cycle N+1: we=0, oob_err=1; write_addr and write_data hold their previous values.
- Cycles with no transfer and no clear: we=0; write_addr and write_data hold their previous values.

Optional Feature:
- Macro: VRAM_WR_RR_ARB_EN.
- Defined: round-robin arbitration between p0 and p1 as above.
- Undefined: fixed priority, p0 always wins on contention; the pointer logic is removed.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset then p0 pixel x=3, y=2, color=12'hF00 -> one cycle later we=1, write_addr=1283, write_data=12'hF00; p0_ready=1 in the accept cycle.
- p0 and p1 valid continuously for 4 cycles:
  - With VRAM_WR_RR_ARB_EN: grants alternate p0, p1, p0, p1 (4 writes).
  - Without the macro: four p0 grants, p1_ready stays 0.
- clear_start with clear_color=12'h0A5, p1_valid held high:
  - 307200 consecutive we=1 cycles, addresses 0..307199, all data 12'h0A5.
  - p1_ready=0 throughout; clear_busy falls after the last write; p1 accepted on the first IDLE cycle.
- p1 pixel x=640, y=0, then x=0, y=480 -> each gives an oob_err pulse with we=0 one cycle after accept; no write.
- Assert reset at clear address 1000 -> we=0 the next cycle, clear_busy=0, state IDLE; a new pixel is then accepted normally.
- clear_start asserted during CLEAR at address 5000 -> ignored; the clear still finishes at 307199 with no restart.
